decode_stage_skid: RTL and testbench
====================================

// Module: decode_stage_skid
// PURPOSE
//  N-lane decode pipeline stage between the fetch queue (f_d_pkg_t) and rename (d_r_pkg_t).
//  Decodes every lane with basic_decoder, derives per-lane PC, arch-reg ids and need/imm flags.
//  Registers results in a 2-entry skid buffer, giving full throughput with a registered in_ready.
//  Adds flush, empty-packet squash and a decoded-instruction counter.
// PARAMETERS
//  LANES     2   decode lanes per packet; power of two, 1..8
//  CNT_W     32  width of the decoded-instruction counter
// PORTS
//  clk            in   1               clock
//  rst_n          in   1               synchronous reset, active low
//  flush_i        in   1               pipeline flush (branch mispredict / exception)
//  in_valid_i     in   1               fetch packet valid
//  in_ready_o     out  1               stage can accept a packet
//  in_mask_i      in   LANES           per-lane valid inside the packet
//  in_pc_i        in   32              PC of lane 0
//  in_insts_i     in   LANES*32        raw instructions, lane 0 in the low bits
//  out_valid_o    out  1               decoded packet valid
//  out_ready_i    in   1               rename accepts the packet
//  out_mask_o     out  LANES           registered copy of in_mask_i
//  out_pc_o       out  LANES*32        per-lane PC
//  out_info_o     out  LANES*$bits(d_decoder_info_t)  basic_decoder output per lane
//  out_r_arfid_o  out  LANES*2*5       source arch regs; slot 2i = r0, slot 2i+1 = r1
//  out_w_arfid_o  out  LANES*5         destination arch reg
//  out_reg_need_o out  LANES*2         source reg type != _REG_ZERO
//  out_use_imm_o  out  LANES*2         source reg type == _REG_IMM
//  dec_cnt_o      out  CNT_W           number of valid lanes accepted by rename
// BEHAVIOUR
//  Reset (rst_n low at a clk edge): main/skid valids 0, dec_cnt_o 0, out_valid_o 0, in_ready_o 1.
//    Data registers are not reset. Reset mid-transfer drops both buffered packets.
//  PC: lane i = {in_pc_i[31:2+log2(LANES)], i[log2(LANES)-1:0], 2'b00}. LANES=1 passes in_pc_i[31:2],2'b00.
//  Arch ids: rd = inst[4:0], rj = inst[9:5], rk = inst[14:10].
//    r0/r1 select rd/rj/rk per reg_type, else 0. IMM also yields 0.
//    w select: _REG_W_RD -> rd, _REG_W_RJ -> rj, _REG_W_R1 -> 1, else 0.
//  Decode is combinational on the input. Results are captured at the accept edge.
//    Latency 1 cycle from accept to out_valid_o.
//  Accept: in_valid_i & in_ready_o & !flush_i & |in_mask_i.
//    A packet with mask 0 is consumed (counts as a handshake) but not stored.
//  in_ready_o = !skid_valid. It is a register output only; it does not depend on out_ready_i.
//  Buffer states: EMPTY (main 0, skid 0), ONE (main 1, skid 0), FULL (main 1, skid 1).
//    EMPTY: accept -> ONE.
//    ONE: accept & out_ready_i -> ONE with new data in main.
//    ONE: accept & !out_ready_i -> FULL, new data in skid.
//    ONE: !accept & out_ready_i -> EMPTY.
//    FULL: out_ready_i -> ONE, skid moves to main. No accept is possible because in_ready_o = 0.
//  Order is preserved. The output is always the main entry. out_* holds stable while out_valid_o & !out_ready_i.
//  flush_i: on the next edge both valids go to 0 and the input packet is dropped. Priority over accept and reset-free counter update.
//    The output handshake in the flush cycle still increments dec_cnt_o if out_ready_i is high.
//  dec_cnt_o += popcount(out_mask_o) on each out_valid_o & out_ready_i. It wraps modulo 2^CNT_W.
// TESTING
//  1. After reset, one packet: pc=0x1C000008, mask=2'b11, insts={ADDI.W r5,r4,1 ; ADD.W r3,r1,r2}.
//     Next cycle: out_valid_o=1, out_pc_o={0x1C00000C,0x1C000008}, w_arfid={5,3}, r_arfid lane0={1,2}, use_imm lane1 r1=1.
//  2. out_ready_i=0 with 3 back-to-back packets: first 2 accepted, then in_ready_o=0.
//     Release out_ready_i: outputs appear in order A,B,C with no loss and no duplicate.
//  3. Continuous in_valid_i & out_ready_i for 100 cycles with mask=11: 100 packets out, dec_cnt_o=200.
//  4. FULL state and flush_i=1 with in_valid_i=1: next cycle out_valid_o=0, in_ready_o=1, nothing from before the flush appears.
//  5. mask=2'b00 packet: in_ready_o handshake occurs, out_valid_o stays 0, dec_cnt_o unchanged.
//     mask=2'b10 packet: dec_cnt_o +1.
//  6. LANES=4, pc=0x1000: lane PCs 0x1000,0x1004,0x1008,0x100C. rst_n low while FULL -> next cycle all valids 0.

Source files
------------

// File: rtl/decode_stage_skid.sv
// N-lane decode stage: per-lane basic decode, lane PC and arch-reg derivation,
// registered through a 2-entry skid buffer with flush, empty-packet squash and a lane counter.

package decode_stage_skid_pkg;
  typedef enum logic [2:0] {
    _REG_ZERO = 3'd0,
    _REG_RD   = 3'd1,
    _REG_RJ   = 3'd2,
    _REG_RK   = 3'd3,
    _REG_IMM  = 3'd4
  } reg_type_t;

  typedef enum logic [1:0] {
    _REG_W_NONE = 2'd0,
    _REG_W_RD   = 2'd1,
    _REG_W_RJ   = 2'd2,
    _REG_W_R1   = 2'd3
  } reg_w_t;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_LUI  = 4'd3,
    ALU_BL   = 4'd4,
    ALU_BEQ  = 4'd5
  } alu_op_t;

  typedef struct packed {
    logic      valid;
    alu_op_t   alu_op;
    reg_type_t r0_type;
    reg_type_t r1_type;
    reg_w_t    w_type;
  } d_decoder_info_t;

  // Encoding chosen so bit 0 is "main valid" and bit 1 is "skid valid".
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b11
  } buf_state_t;
endpackage

module basic_decoder
  import decode_stage_skid_pkg::*;
(
  input  logic [16:0]     i_op,
  output d_decoder_info_t o_info
);
  // i_op is inst[31:15]; register fields are extracted by the stage.
  always_comb begin
    o_info = '0;
    if (i_op == 17'h00020) begin
      o_info = '{1'b1, ALU_ADD, _REG_RJ, _REG_RK, _REG_W_RD};
    end else if (i_op == 17'h00022) begin
      o_info = '{1'b1, ALU_SUB, _REG_RJ, _REG_RK, _REG_W_RD};
    end else if (i_op[16:7] == 10'b0000001010) begin
      o_info = '{1'b1, ALU_ADD, _REG_RJ, _REG_IMM, _REG_W_RD};
    end else if (i_op[16:10] == 7'b0001010) begin
      o_info = '{1'b1, ALU_LUI, _REG_ZERO, _REG_IMM, _REG_W_RD};
    end else if (i_op[16:11] == 6'b010101) begin
      o_info = '{1'b1, ALU_BL, _REG_ZERO, _REG_IMM, _REG_W_R1};
    end else if (i_op[16:11] == 6'b010110) begin
      o_info = '{1'b1, ALU_BEQ, _REG_RJ, _REG_RD, _REG_W_NONE};
    end
  end
endmodule

module decode_stage_skid
  import decode_stage_skid_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CNT_W = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [LANES-1:0]                       in_mask_i,
  input  logic [31:0]                            in_pc_i,
  input  logic [LANES*32-1:0]                    in_insts_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [LANES-1:0]                       out_mask_o,
  output logic [LANES*32-1:0]                    out_pc_o,
  output logic [LANES*$bits(d_decoder_info_t)-1:0] out_info_o,
  output logic [LANES*10-1:0]                    out_r_arfid_o,
  output logic [LANES*5-1:0]                     out_w_arfid_o,
  output logic [LANES*2-1:0]                     out_reg_need_o,
  output logic [LANES*2-1:0]                     out_use_imm_o,
  output logic [CNT_W-1:0]                       dec_cnt_o,
  output logic [1:0]                             dbg_state_o
);
  localparam int          INFO_W      = $bits(d_decoder_info_t);
  localparam logic [31:0] PC_LOW_MASK = 32'(4 * LANES - 1);

  typedef struct packed {
    logic [31:0]     pc;
    d_decoder_info_t info;
    logic [4:0]      r0;
    logic [4:0]      r1;
    logic [4:0]      w;
    logic [1:0]      need;
    logic [1:0]      imm;
  } lane_t;

  typedef struct packed {
    logic [LANES-1:0]       mask;
    lane_t [LANES-1:0]      lane;
  } pkt_t;

  function automatic logic [4:0] sel_src(input reg_type_t t, input logic [14:0] f);
    case (t)
      _REG_RD: sel_src = f[4:0];
      _REG_RJ: sel_src = f[9:5];
      _REG_RK: sel_src = f[14:10];
      default: sel_src = 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] sel_dst(input reg_w_t t, input logic [14:0] f);
    case (t)
      _REG_W_RD: sel_dst = f[4:0];
      _REG_W_RJ: sel_dst = f[9:5];
      _REG_W_R1: sel_dst = 5'd1;
      default:   sel_dst = 5'd0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] m);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int i = 0; i < LANES; i++) s = s + CNT_W'(m[i]);
    return s;
  endfunction

  d_decoder_info_t w_info [LANES];
  pkt_t            w_pkt;
  pkt_t            r_main;
  pkt_t            r_skid;
  buf_state_t      r_state;
  buf_state_t      w_state_nxt;
  logic            w_accept;
  logic            w_pop;
  logic            w_load_main_in;
  logic            w_load_main_skid;
  logic            w_load_skid;
  logic [CNT_W-1:0] r_dec_cnt;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_dec
    basic_decoder u_dec (
      .i_op   (in_insts_i[32*gi+15 +: 17]),
      .o_info (w_info[gi])
    );
  end

  always_comb begin
    w_pkt      = '0;
    w_pkt.mask = in_mask_i;
    for (int i = 0; i < LANES; i++) begin
      w_pkt.lane[i].pc      = (in_pc_i & ~PC_LOW_MASK) | (32'(i) << 2);
      w_pkt.lane[i].info    = w_info[i];
      w_pkt.lane[i].r0      = sel_src(w_info[i].r0_type, in_insts_i[32*i +: 15]);
      w_pkt.lane[i].r1      = sel_src(w_info[i].r1_type, in_insts_i[32*i +: 15]);
      w_pkt.lane[i].w       = sel_dst(w_info[i].w_type, in_insts_i[32*i +: 15]);
      w_pkt.lane[i].need[0] = (w_info[i].r0_type != _REG_ZERO);
      w_pkt.lane[i].need[1] = (w_info[i].r1_type != _REG_ZERO);
      w_pkt.lane[i].imm[0]  = (w_info[i].r0_type == _REG_IMM);
      w_pkt.lane[i].imm[1]  = (w_info[i].r1_type == _REG_IMM);
    end
  end

  // Handshakes: in side transfers on in_valid_i & in_ready_o (dropped under flush_i);
  // out side transfers on out_valid_o & out_ready_i. Empty-mask packets handshake but are not stored.
  assign in_ready_o  = ~r_state[1];
  assign out_valid_o = r_state[0];
  assign dbg_state_o = r_state;
  assign w_pop       = r_state[0] & out_ready_i;
  assign w_accept    = in_valid_i & in_ready_o & ~flush_i & (|in_mask_i);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= BUF_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush_i) begin
      w_state_nxt = BUF_EMPTY;
    end else begin
      case (r_state)
        BUF_EMPTY: if (w_accept) begin
          w_state_nxt    = BUF_ONE;
          w_load_main_in = 1'b1;
        end
        BUF_ONE: if (w_accept && w_pop) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = BUF_FULL;
          w_load_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = BUF_EMPTY;
        end
        BUF_FULL: if (w_pop) begin
          w_state_nxt      = BUF_ONE;
          w_load_main_skid = 1'b1;
        end
        default: w_state_nxt = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_main_in)        r_main <= w_pkt;
    else if (w_load_main_skid) r_main <= r_skid;
    if (w_load_skid)           r_skid <= w_pkt;
  end

  // The output handshake still counts in a flush cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)     r_dec_cnt <= '0;
    else if (w_pop) r_dec_cnt <= r_dec_cnt + popcount(r_main.mask);
  end

  assign dec_cnt_o  = r_dec_cnt;
  assign out_mask_o = r_main.mask;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_out
    assign out_pc_o[32*gi +: 32]          = r_main.lane[gi].pc;
    assign out_info_o[INFO_W*gi +: INFO_W] = r_main.lane[gi].info;
    assign out_r_arfid_o[10*gi +: 5]      = r_main.lane[gi].r0;
    assign out_r_arfid_o[10*gi+5 +: 5]    = r_main.lane[gi].r1;
    assign out_w_arfid_o[5*gi +: 5]       = r_main.lane[gi].w;
    assign out_reg_need_o[2*gi +: 2]      = r_main.lane[gi].need;
    assign out_use_imm_o[2*gi +: 2]       = r_main.lane[gi].imm;
  end
endmodule

// File: tb/tb_decode_stage_skid.sv
// Bench for decode_stage_skid: a 2-lane instance with a scoreboard and a 4-lane
// instance (4-bit counter) for lane PCs, reset while full and counter wrap.

module tb_decode_stage_skid;
  localparam int EXP_W = 104;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         flush2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [1:0]   in_mask2, out_mask2, dbg2;
  logic [31:0]  in_pc2, dec_cnt2;
  logic [63:0]  in_insts2, out_pc2;
  logic [25:0]  out_info2;
  logic [19:0]  out_r2;
  logic [9:0]   out_w2;
  logic [3:0]   out_need2, out_imm2;

  logic         flush4, in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]   in_mask4, out_mask4, dec_cnt4;
  logic [1:0]   dbg4;
  logic [31:0]  in_pc4;
  logic [127:0] in_insts4, out_pc4;
  logic [51:0]  out_info4;
  logic [39:0]  out_r4;
  logic [19:0]  out_w4;
  logic [7:0]   out_need4, out_imm4;

  decode_stage_skid #(.LANES(2), .CNT_W(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush2), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .in_mask_i(in_mask2), .in_pc_i(in_pc2), .in_insts_i(in_insts2), .out_valid_o(out_valid2),
    .out_ready_i(out_ready2), .out_mask_o(out_mask2), .out_pc_o(out_pc2), .out_info_o(out_info2),
    .out_r_arfid_o(out_r2), .out_w_arfid_o(out_w2), .out_reg_need_o(out_need2),
    .out_use_imm_o(out_imm2), .dec_cnt_o(dec_cnt2), .dbg_state_o(dbg2)
  );

  decode_stage_skid #(.LANES(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush4), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .in_mask_i(in_mask4), .in_pc_i(in_pc4), .in_insts_i(in_insts4), .out_valid_o(out_valid4),
    .out_ready_i(out_ready4), .out_mask_o(out_mask4), .out_pc_o(out_pc4), .out_info_o(out_info4),
    .out_r_arfid_o(out_r4), .out_w_arfid_o(out_w4), .out_reg_need_o(out_need4),
    .out_use_imm_o(out_imm4), .dec_cnt_o(dec_cnt4), .dbg_state_o(dbg4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] sb_exp, sb_act;

  typedef struct packed {
    logic [4:0] r0, r1, w;
    logic need0, need1, imm0, imm1;
  } ref_t;

  // Reference decode of the supported LoongArch subset.
  function automatic ref_t ref_dec(input logic [31:0] inst);
    ref_t rf;
    rf = '0;
    if (inst[31:15] == 17'h00020 || inst[31:15] == 17'h00022) begin
      rf.r0 = inst[9:5]; rf.r1 = inst[14:10]; rf.w = inst[4:0]; rf.need0 = 1; rf.need1 = 1;
    end else if (inst[31:22] == 10'h00A) begin
      rf.r0 = inst[9:5]; rf.w = inst[4:0]; rf.need0 = 1; rf.need1 = 1; rf.imm1 = 1;
    end else if (inst[31:25] == 7'h0A) begin
      rf.w = inst[4:0]; rf.need1 = 1; rf.imm1 = 1;
    end else if (inst[31:26] == 6'h15) begin
      rf.w = 5'd1; rf.need1 = 1; rf.imm1 = 1;
    end else if (inst[31:26] == 6'h16) begin
      rf.r0 = inst[9:5]; rf.r1 = inst[4:0]; rf.need0 = 1; rf.need1 = 1;
    end
    return rf;
  endfunction

  function automatic logic [EXP_W-1:0] build_exp(input logic [1:0] mask, input logic [31:0] pc,
                                                 input logic [63:0] insts);
    logic [63:0] pcs;
    logic [19:0] r;
    logic [9:0]  w;
    logic [3:0]  need, imm;
    ref_t        rf;
    for (int i = 0; i < 2; i++) begin
      rf = ref_dec(insts[32*i +: 32]);
      pcs[32*i +: 32] = {pc[31:3], i[0], 2'b00};
      w[5*i +: 5]     = rf.w;
      r[10*i +: 5]    = rf.r0;
      r[10*i+5 +: 5]  = rf.r1;
      need[2*i +: 2]  = {rf.need1, rf.need0};
      imm[2*i +: 2]   = {rf.imm1, rf.imm0};
    end
    return {mask, pcs, w, r, need, imm};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: return {17'h00020, r[14:0]};
      1: return {17'h00022, r[14:0]};
      2: return {10'h00A, r[21:0]};
      3: return {7'h0A, r[24:0]};
      4: return {6'h15, r[25:0]};
      5: return {6'h16, r[25:0]};
      default: return r;
    endcase
  endfunction

  // Scoreboard: every output handshake on the 2-lane instance pops one expected packet.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid2 === 1'b1 && out_ready2 === 1'b1) begin
      sb_act = {out_mask2, out_pc2, out_w2, out_r2, out_need2, out_imm2};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got %h, required no output", sb_act);
      end else begin
        sb_exp = exp_q.pop_front();
        n_out++;
        exp_cnt = exp_cnt + 32'(sb_exp[EXP_W-1]) + 32'(sb_exp[EXP_W-2]);
        if (sb_act !== sb_exp) begin
          n_bad++;
          $display("FAIL sb_packet: got %h, required %h", sb_act, sb_exp);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; in_valid2 = 1'b0; flush2 = 1'b0; in_valid4 = 1'b0; flush4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_cnt = 32'd0;
  endtask

  task automatic send(input logic [1:0] mask, input logic [31:0] pc, input logic [63:0] insts,
                      output int waited);
    bit done;
    done = 0; waited = 0;
    in_valid2 = 1'b1; in_mask2 = mask; in_pc2 = pc; in_insts2 = insts;
    while (!done && waited < 200) begin
      @(negedge clk);
      if (in_ready2 === 1'b1) begin
        done = 1;
        if (mask != 2'b00) exp_q.push_back(build_exp(mask, pc, insts));
      end
      waited++;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready_o=%b, required 1 within 200 cycles", in_ready2);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid2 = 1'b0; out_ready2 = 1'b1;
    while ((exp_q.size() != 0 || out_valid2 !== 1'b0) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || out_valid2 !== 1'b0) begin
      n_bad++;
      $display("FAIL drain: %0d pending, out_valid_o=%b, required 0 pending and 0", exp_q.size(), out_valid2);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (out_valid2 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b, required 0", out_valid2); end
    n_cmp++; if (in_ready2 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b, required 1", in_ready2); end
    n_cmp++; if (dec_cnt2 !== 32'd0) begin n_bad++; $display("FAIL reset_dec_cnt: got %0d, required 0", dec_cnt2); end
    n_cmp++; if (dbg2 !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b, required 00", dbg2); end
    n_cmp++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      n_bad++; $display("FAIL reset_lanes4: valid=%b ready=%b, required 0/1", out_valid4, in_ready4);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_decode();
    int w;
    out_ready2 = 1'b1;
    send(2'b11, 32'h1C000008, {32'h02800485, 32'h00100823}, w);
    in_valid2 = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid2 !== 1'b1) begin n_bad++; $display("FAIL dec_valid: got %b, required 1", out_valid2); end
    n_cmp++; if (out_pc2 !== {32'h1C00000C, 32'h1C000008}) begin
      n_bad++; $display("FAIL dec_pc: got %h, required 1c00000c1c000008", out_pc2);
    end
    n_cmp++; if (out_w2 !== {5'd5, 5'd3}) begin n_bad++; $display("FAIL dec_w_arfid: got %h, required %h", out_w2, {5'd5, 5'd3}); end
    n_cmp++; if (out_r2[9:0] !== {5'd2, 5'd1}) begin n_bad++; $display("FAIL dec_r_arfid0: got %h, required %h", out_r2[9:0], {5'd2, 5'd1}); end
    n_cmp++; if (out_imm2 !== 4'b1000) begin n_bad++; $display("FAIL dec_use_imm: got %b, required 1000", out_imm2); end
    n_cmp++; if (out_info2[12:0] !== 13'h114D) begin n_bad++; $display("FAIL dec_info0: got %h, required 114d", out_info2[12:0]); end
    @(posedge clk);
    #1;
    drain();
    n_cmp++; if (dec_cnt2 !== 32'd2) begin n_bad++; $display("FAIL dec_cnt_after_one: got %0d, required 2", dec_cnt2); end
  endtask

  task automatic test_back_to_back();
    int w, n0;
    logic [31:0] pa, pb, pc;
    logic [63:0] ia, ib, ic;
    pa = $urandom; pb = $urandom; pc = $urandom;
    ia = {rand_inst(), rand_inst()}; ib = {rand_inst(), rand_inst()}; ic = {rand_inst(), rand_inst()};
    n0 = n_out;
    out_ready2 = 1'b0;
    send(2'b11, pa, ia, w);
    send(2'b01, pb, ib, w);
    in_valid2 = 1'b1; in_mask2 = 2'b11; in_pc2 = pc; in_insts2 = ic;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (in_ready2 !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_full: got %b, required 0", in_ready2); end
      n_cmp++; if (out_pc2[31:0] !== {pa[31:3], 3'b000}) begin
        n_bad++; $display("FAIL b2b_hold_pc: got %h, required %h", out_pc2[31:0], {pa[31:3], 3'b000});
      end
      @(posedge clk);
      #1;
    end
    n_cmp++; if (dbg2 !== 2'b11) begin n_bad++; $display("FAIL b2b_state: got %b, required 11", dbg2); end
    out_ready2 = 1'b1;
    send(2'b11, pc, ic, w);
    drain();
    n_cmp++; if (n_out - n0 !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d, required 3", n_out - n0); end
    n_cmp++; if (dec_cnt2 !== exp_cnt) begin n_bad++; $display("FAIL b2b_dec_cnt: got %0d, required %0d", dec_cnt2, exp_cnt); end
  endtask

  task automatic test_throughput();
    int w, total, n0;
    do_reset();
    n0 = n_out; total = 0;
    out_ready2 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      send(2'b11, $urandom, {rand_inst(), rand_inst()}, w);
      total += w;
    end
    in_valid2 = 1'b0;
    n_cmp++; if (total !== 100) begin n_bad++; $display("FAIL tput_cycles: got %0d, required 100", total); end
    drain();
    n_cmp++; if (n_out - n0 !== 100) begin n_bad++; $display("FAIL tput_packets: got %0d, required 100", n_out - n0); end
    n_cmp++; if (dec_cnt2 !== 32'd200) begin n_bad++; $display("FAIL tput_dec_cnt: got %0d, required 200", dec_cnt2); end
  endtask

  task automatic test_flush();
    int w;
    logic [31:0] c0;
    out_ready2 = 1'b0;
    send(2'b11, $urandom, {rand_inst(), rand_inst()}, w);
    send(2'b11, $urandom, {rand_inst(), rand_inst()}, w);
    in_valid2 = 1'b1; in_mask2 = 2'b11; in_pc2 = $urandom; flush2 = 1'b1;
    @(posedge clk);
    #1;
    flush2 = 1'b0; in_valid2 = 1'b0;
    exp_q.delete();
    c0 = exp_cnt;
    @(negedge clk);
    n_cmp++; if (out_valid2 !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b, required 0", out_valid2); end
    n_cmp++; if (in_ready2 !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b, required 1", in_ready2); end
    n_cmp++; if (dbg2 !== 2'b00) begin n_bad++; $display("FAIL flush_state: got %b, required 00", dbg2); end
    out_ready2 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (dec_cnt2 !== c0) begin n_bad++; $display("FAIL flush_cnt_hold: got %0d, required %0d", dec_cnt2, c0); end
    // Flush in the same cycle as an output handshake.
    out_ready2 = 1'b0;
    send(2'b11, $urandom, {rand_inst(), rand_inst()}, w);
    out_ready2 = 1'b1; flush2 = 1'b1; in_pc2 = $urandom;
    @(posedge clk);
    #1;
    flush2 = 1'b0; in_valid2 = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid2 !== 1'b0) begin n_bad++; $display("FAIL flush_pop_valid: got %b, required 0", out_valid2); end
    n_cmp++; if (dec_cnt2 !== c0 + 32'd2) begin n_bad++; $display("FAIL flush_pop_cnt: got %0d, required %0d", dec_cnt2, c0 + 32'd2); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mask();
    int w;
    logic [31:0] c0;
    c0 = exp_cnt;
    out_ready2 = 1'b1;
    send(2'b00, $urandom, {rand_inst(), rand_inst()}, w);
    in_valid2 = 1'b0;
    n_cmp++; if (w !== 1) begin n_bad++; $display("FAIL mask0_handshake: took %0d cycles, required 1", w); end
    @(negedge clk);
    n_cmp++; if (out_valid2 !== 1'b0) begin n_bad++; $display("FAIL mask0_valid: got %b, required 0", out_valid2); end
    @(posedge clk);
    #1;
    n_cmp++; if (dec_cnt2 !== c0) begin n_bad++; $display("FAIL mask0_cnt: got %0d, required %0d", dec_cnt2, c0); end
    send(2'b10, $urandom, {rand_inst(), rand_inst()}, w);
    drain();
    n_cmp++; if (dec_cnt2 !== c0 + 32'd1) begin n_bad++; $display("FAIL mask10_cnt: got %0d, required %0d", dec_cnt2, c0 + 32'd1); end
  endtask

  task automatic test_lanes4();
    out_ready4 = 1'b0; in_valid4 = 1'b1; in_mask4 = 4'hF; in_pc4 = 32'h1000;
    in_insts4 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    n_cmp++; if (in_ready4 !== 1'b1) begin n_bad++; $display("FAIL l4_ready_empty: got %b, required 1", in_ready4); end
    @(posedge clk);
    #1;
    in_pc4 = 32'h2000;
    @(negedge clk);
    n_cmp++; if (out_pc4 !== {32'h100C, 32'h1008, 32'h1004, 32'h1000}) begin
      n_bad++; $display("FAIL l4_pc: got %h, required 0000100c000010080000100400001000", out_pc4);
    end
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    @(negedge clk);
    n_cmp++; if (dbg4 !== 2'b11 || in_ready4 !== 1'b0) begin
      n_bad++; $display("FAIL l4_full: state=%b ready=%b, required 11/0", dbg4, in_ready4);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete(); exp_cnt = 32'd0;
    @(negedge clk);
    n_cmp++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || dbg4 !== 2'b00) begin
      n_bad++; $display("FAIL l4_reset_full: valid=%b ready=%b state=%b, required 0/1/00", out_valid4, in_ready4, dbg4);
    end
    @(posedge clk);
    #1;
    out_ready4 = 1'b1; in_valid4 = 1'b1; in_mask4 = 4'hF;
    repeat (5) @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (dec_cnt4 !== 4'd4) begin n_bad++; $display("FAIL l4_cnt_wrap: got %0d, required 4", dec_cnt4); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    flush2 = 1'b0; in_valid2 = 1'b0; in_mask2 = 2'b00; in_pc2 = 32'd0; in_insts2 = 64'd0; out_ready2 = 1'b0;
    flush4 = 1'b0; in_valid4 = 1'b0; in_mask4 = 4'h0; in_pc4 = 32'd0; in_insts4 = 128'd0; out_ready4 = 1'b0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_throughput();
    test_flush();
    test_mask();
    test_lanes4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
